mesh_xy_router: RTL and testbench
=================================

# mesh_xy_router

Five-port, input-buffered mesh router node that carries read and write packets between neighbouring tiles and a local endpoint using dimension-ordered (X then Y) routing. It is the parametrised successor to the fixed-width mesh packet definitions. Coordinate, address and data widths, and FIFO depth, are parameters. It adds per-input buffering, per-output round-robin arbitration and registered outputs with valid/ready backpressure. One instance sits at every tile of the mesh, and neighbouring instances are wired port to port.

## Interface
- X_W, 15: destination/source x coordinate width.
- Y_W, 15: y coordinate width.
- ADDR_W, 34: memory address width.
- DATA_W, 64: write data width.
- DEPTH, 4: entries per input FIFO; power of two, ≥2.
- Derived widths:
  - A_W = X_W+Y_W+ADDR_W.
  - PKT_W = 1 + A_W + max(A_W, DATA_W). Default is 129.
- Packet layout:
  - [PKT_W-1]: type, 0 = read, 1 = write.
  - Next A_W bits: dest {x, y, addr}.
  - Remaining bits: req_address {x, y, addr} for reads, or data (LSB-aligned) for writes.
- Port index: 0 = Local, 1 = North (+y), 2 = East (+x), 3 = South (−y), 4 = West (−x).

Ports:
- clk  in  1  sole clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- my_x  in  X_W  this node's x coordinate; quasi-static.
- my_y  in  Y_W  this node's y coordinate; quasi-static.
- in_valid  in  5  per-port packet valid.
- in_ready  out  5  per-port FIFO not full.
- in_packet  in  5×PKT_W  per-port packet.
- out_valid  out  5  per-port output register valid.
- out_ready  in  5  per-port downstream ready.
- out_packet  out  5×PKT_W  per-port output packet.
- out_count  out  5×32  forwarded-packet counters; present only with MESH_ROUTER_STATS_EN.

## Operation
- **Input acceptance:** input i accepts a packet on a cycle with in_valid[i] & in_ready[i], and pushes it into FIFO i.
- **in_ready:** in_ready[i] = !full[i], taken from registered occupancy. It does not depend on a same-cycle pop.
- **Route computation:** combinational, from the FIFO head's dest, using unsigned compares:
  - dx > my_x → East; dx < my_x → West.
  - Otherwise dy > my_y → North; dy < my_y → South.
  - Otherwise → Local.
- **Output register:** each output o has one register (valid + packet). It can load when !out_valid[o] | out_ready[o].
- **Arbitration:** per output, round-robin among non-empty inputs whose head routes to o.
  - Priority starts at rr_ptr[o]+1, mod 5.
  - On a grant, rr_ptr[o] ← granted input and the input's FIFO pops. With no grant, rr_ptr[o] is unchanged.
  - Each input's head requests exactly one output, so each FIFO pops at most once per cycle.
- **No transformation:** packets are forwarded unchanged. There is no U-turn check; a head routed to its own arrival port is forwarded normally.
- **Simultaneous push and pop:** allowed on any FIFO.
  - Push into an empty FIFO: the new head is visible the next cycle.
  - Pop from a full FIFO: in_ready rises the following cycle.
- **Ordering:** per (input, output) pair, packets leave in arrival order.
- **Reset (async assert, any time):**
  - All FIFOs empty; in_ready = 5'b11111 after the first clock edge with rst_n high.
  - out_valid = 0; out_packet = 0.
  - rr_ptr = 4 for every output, so input 0 has first priority.
  - out_count = 0.
  - A packet in flight is dropped.

## Timing
- **Minimum latency:** 2 cycles. Accepted at edge t, the packet is in the FIFO after t and loaded into the output register at edge t+1, so out_valid is seen after t+1.
- **Throughput:** 1 packet/cycle per output under continuous out_ready.
- **Stall:** with out_ready[o] = 0 and out_valid[o] = 1, out_packet[o] holds stable and no grant is made to o.
- **FIFO pointers:** log2(DEPTH) bits with wrap-around. Occupancy is a log2(DEPTH)+1 bit count, so full and empty are unambiguous.

## Configuration
- **MESH_ROUTER_STATS_EN defined:**
  - out_count[o] increments by 1 on each out_valid[o] & out_ready[o].
  - 32-bit, wraps 0xFFFFFFFF → 0; reset to 0.
- **Not defined:** the out_count port and its counters are absent. All other behaviour is identical.

## Test plan
- **Routing:** my = (5,5); inject on Local writes to (7,5), (3,5), (5,9), (5,1), (5,5).
  - Each exits East, West, North, South, Local respectively, 2 cycles after acceptance, with the packet bit-exact.
- **Backpressure and full FIFO:** DEPTH = 4; out_ready[East] = 0; stream 6 East-bound packets into input 0.
  - 1 packet sits in the output register and 4 fill the FIFO; in_ready[0] falls after the 5th acceptance.
  - Raising out_ready delivers all 5 accepted packets in order and in_ready recovers.
- **Round-robin:** inputs 1–4 continuously send Local-bound packets; out_ready[0] = 1.
  - Grants follow 1, 2, 3, 4, 1, …, and each input gets every 4th slot.
- **Simultaneous events:** Local→East and North→South in the same cycle.
  - Both emerge on the same later cycle; FIFO push and pop on the same cycle keep occupancy constant.
- **Reset mid-traffic:** drop rst_n with 3 packets buffered.
  - out_valid goes to 0 immediately (asynchronously); after release, no stale packets emerge.
- **Stats (MESH_ROUTER_STATS_EN):** preload traffic of 10 East packets.
  - out_count[East] = 10 and all other counters = 0.

Source files
------------

// File: rtl/mesh_xy_router_if.sv
// Bundled per-port handshake buses of the mesh router: five input links and five output links.
// out_count exists only when MESH_ROUTER_STATS_EN is defined.
interface mesh_xy_router_if #(
    parameter int X_W    = 15,
    parameter int Y_W    = 15,
    parameter int ADDR_W = 34,
    parameter int DATA_W = 64
);
    localparam int A_W   = X_W + Y_W + ADDR_W;
    localparam int PKT_W = 1 + A_W + ((A_W > DATA_W) ? A_W : DATA_W);

    logic [4:0]            in_valid;
    logic [4:0]            in_ready;
    logic [4:0][PKT_W-1:0] in_packet;
    logic [4:0]            out_valid;
    logic [4:0]            out_ready;
    logic [4:0][PKT_W-1:0] out_packet;
`ifdef MESH_ROUTER_STATS_EN
    logic [4:0][31:0]      out_count;

    modport slave  (input  in_valid, in_packet, out_ready,
                    output in_ready, out_valid, out_packet, out_count);
    modport master (output in_valid, in_packet, out_ready,
                    input  in_ready, out_valid, out_packet, out_count);
`else
    modport slave  (input  in_valid, in_packet, out_ready,
                    output in_ready, out_valid, out_packet);
    modport master (output in_valid, in_packet, out_ready,
                    input  in_ready, out_valid, out_packet);
`endif
endinterface

// File: rtl/mesh_xy_router.sv
// Five-port input-buffered XY mesh router: per-input FIFO + route lane, per-output round-robin
// arbiter feeding a registered output. Define MESH_ROUTER_STATS_EN for per-output forward counters.
module mesh_xy_router_lane #(
    parameter int X_W   = 15,
    parameter int Y_W   = 15,
    parameter int PKT_W = 129,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [X_W-1:0]   my_x_i,
    input  logic [Y_W-1:0]   my_y_i,
    input  logic             push_i,
    input  logic [PKT_W-1:0] data_i,
    input  logic             pop_i,
    output logic [PKT_W-1:0] head_o,
    output logic             full_o,
    output logic [4:0]       req_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    logic             empty;
    logic [X_W-1:0]   dx;
    logic [Y_W-1:0]   dy;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign empty  = (cnt_q == '0);
    assign full_o = (cnt_q == (PW+1)'(DEPTH));
    assign head_o = mem_q[rd_q];
    assign dx     = head_o[PKT_W-2 -: X_W];
    assign dy     = head_o[PKT_W-2-X_W -: Y_W];

    // One-hot output request: L=0, N=1, E=2, S=3, W=4; X resolved before Y
    always_comb begin
        req_o = '0;
        if (!empty) begin
            if (dx > my_x_i)      req_o[2] = 1'b1;
            else if (dx < my_x_i) req_o[4] = 1'b1;
            else if (dy > my_y_i) req_o[1] = 1'b1;
            else if (dy < my_y_i) req_o[3] = 1'b1;
            else                  req_o[0] = 1'b1;
        end
    end
endmodule

module mesh_xy_router #(
    parameter int X_W    = 15,
    parameter int Y_W    = 15,
    parameter int ADDR_W = 34,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] my_x,
    input  logic [Y_W-1:0] my_y,
    mesh_xy_router_if.slave bus
);
    localparam int NP    = 5;
    localparam int A_W   = X_W + Y_W + ADDR_W;
    localparam int PKT_W = 1 + A_W + ((A_W > DATA_W) ? A_W : DATA_W);

    logic [NP-1:0][PKT_W-1:0] head;
    logic [NP-1:0]            full, pop, can_load;
    logic [NP-1:0][NP-1:0]    req;   // req[input][output]
    logic [NP-1:0][NP-1:0]    gnt;   // gnt[output][input]
    logic [NP-1:0][2:0]       rr_q, rr_d;
    logic [NP-1:0]            ovld_q, ovld_d;
    logic [NP-1:0][PKT_W-1:0] opkt_q, opkt_d;
    int                       idx;
    logic                     found;

    for (genvar i = 0; i < NP; i++) begin : g_lane
        mesh_xy_router_lane #(.X_W(X_W), .Y_W(Y_W), .PKT_W(PKT_W), .DEPTH(DEPTH)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .my_x_i (my_x),
            .my_y_i (my_y),
            .push_i (bus.in_valid[i] & ~full[i]),
            .data_i (bus.in_packet[i]),
            .pop_i  (pop[i]),
            .head_o (head[i]),
            .full_o (full[i]),
            .req_o  (req[i])
        );
    end

    assign can_load = ~ovld_q | bus.out_ready;

    // Round-robin search starts just after the last granted input
    always_comb begin
        gnt   = '0;
        rr_d  = rr_q;
        idx   = 0;
        found = 1'b0;
        for (int o = 0; o < NP; o++) begin
            found = 1'b0;
            if (can_load[o]) begin
                for (int k = 1; k <= NP; k++) begin
                    idx = (int'(rr_q[o]) + k) % NP;
                    if (!found && req[idx][o]) begin
                        gnt[o][idx] = 1'b1;
                        rr_d[o]     = 3'(idx);
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pop    = '0;
        ovld_d = ovld_q;
        opkt_d = opkt_q;
        for (int o = 0; o < NP; o++) begin
            pop = pop | gnt[o];
            if (can_load[o]) begin
                ovld_d[o] = |gnt[o];
                for (int i = 0; i < NP; i++)
                    if (gnt[o][i]) opkt_d[o] = head[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= {NP{3'd4}};
            ovld_q <= '0;
            opkt_q <= '0;
        end else begin
            rr_q   <= rr_d;
            ovld_q <= ovld_d;
            opkt_q <= opkt_d;
        end
    end

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ovld_q;
    assign bus.out_packet = opkt_q;

`ifdef MESH_ROUTER_STATS_EN
    logic [NP-1:0][31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int o = 0; o < NP; o++)
                if (ovld_q[o] && bus.out_ready[o]) cnt_q[o] <= cnt_q[o] + 32'd1;
        end
    end

    assign bus.out_count = cnt_q;
`endif
endmodule

// File: tb/tb_mesh_xy_router.sv
// Scoreboard bench for mesh_xy_router at node (5,5): stimulus pushes expected packets per output,
// a negedge monitor pops and compares every out_valid & out_ready handshake.
`timescale 1ns/1ps
module tb_mesh_xy_router;
    localparam int X_W = 15, Y_W = 15, ADDR_W = 34, DATA_W = 64, DEPTH = 4;
    localparam int A_W   = X_W + Y_W + ADDR_W;
    localparam int P_W   = (A_W > DATA_W) ? A_W : DATA_W;
    localparam int PKT_W = 1 + A_W + P_W;
    typedef logic [PKT_W-1:0] pkt_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [X_W-1:0] my_x = X_W'(5);
    logic [Y_W-1:0] my_y = Y_W'(5);

    mesh_xy_router_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mesh_xy_router #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .my_x  (my_x),
        .my_y  (my_y),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_chk  = 0;
    pkt_t exp_q[5][$];
    pkt_t prev_pkt[5];
    logic [4:0] prev_stall = '0;

    task automatic chk(input string nm, input pkt_t act, input pkt_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic pkt_t mk(input logic wr, input int dx, input int dy, input logic [P_W-1:0] pay);
        pkt_t p;
        p = '0;
        p[PKT_W-1] = wr;
        p[PKT_W-2 -: X_W] = X_W'(dx);
        p[PKT_W-2-X_W -: Y_W] = Y_W'(dy);
        p[PKT_W-2-X_W-Y_W -: ADDR_W] = ADDR_W'(34'h2_0000_1000 + pay[15:0]);
        p[P_W-1:0] = pay;
        return p;
    endfunction

    // Monitor: every handshake must match the head of that output's expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                if (prev_stall[o]) chk($sformatf("stall_hold%0d", o), bus.out_packet[o], prev_pkt[o]);
                if (bus.out_valid[o] && bus.out_ready[o]) begin
                    if (exp_q[o].size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_out%0d: got %h expected nothing", o, bus.out_packet[o]);
                    end else begin
                        chk($sformatf("out%0d", o), bus.out_packet[o], exp_q[o].pop_front());
                    end
                end
                prev_stall[o] = bus.out_valid[o] & ~bus.out_ready[o];
                prev_pkt[o]   = bus.out_packet[o];
            end
        end else begin
            prev_stall = '0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid  = '0;
        bus.in_packet = '0;
        bus.out_ready = '0;
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Offers pkt on port p until accepted; returns 1ns after the accepting edge
    task automatic send1(input int p, input pkt_t pkt);
        int n;
        n = 0;
        bus.in_valid[p]  = 1'b1;
        bus.in_packet[p] = pkt;
        while (!bus.in_ready[p] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            $display("FAIL send_timeout port%0d: in_ready stayed %b expected 1", p, bus.in_ready[p]);
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int n, left;
        n = 0;
        left = 1;
        while (left != 0 && n < 300) begin
            left = 0;
            for (int o = 0; o < 5; o++) left += exp_q[o].size();
            if (left != 0) begin
                @(posedge clk); #1;
                n++;
            end
        end
        n_chk++;
        if (left == 0) n_pass++;
        else $display("FAIL drain: %0d packets outstanding expected 0", left);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p, p0, p1;
        int   rdx[5], rdy[5], rout[5];

        // Reset state
        bus.in_valid  = '0;
        bus.in_packet = '0;
        bus.out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", PKT_W'(bus.out_valid), PKT_W'(0));
        chk("rst_out_pkt0", bus.out_packet[0], '0);
        chk("rst_out_pkt4", bus.out_packet[4], '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", PKT_W'(bus.in_ready), PKT_W'(5'h1f));

        // Routing from Local at (5,5): E, W, N, S, L with 2-cycle latency
        rdx  = '{7, 3, 5, 5, 5};
        rdy  = '{5, 5, 9, 1, 5};
        rout = '{2, 4, 1, 3, 0};
        bus.out_ready = 5'h1f;
        for (int k = 0; k < 5; k++) begin
            p = mk(1'b1, rdx[k], rdy[k], P_W'(64'hA000 + k));
            exp_q[rout[k]].push_back(p);
            send1(0, p);
            chk($sformatf("lat_early%0d", k), PKT_W'(bus.out_valid[rout[k]]), PKT_W'(0));
            @(posedge clk); #1;
            chk($sformatf("lat2_valid%0d", k), PKT_W'(bus.out_valid[rout[k]]), PKT_W'(1));
            chk($sformatf("lat2_pkt%0d", k), bus.out_packet[rout[k]], p);
            repeat (2) @(posedge clk); #1;
        end
        wait_drain();

        // Backpressure: East stalled, 1 in output register + 4 in FIFO
        do_reset();
        bus.out_ready = 5'h1b;
        p0 = mk(1'b1, 9, 5, P_W'(64'hB000));
        for (int k = 0; k < 5; k++) begin
            p = mk(1'b1, 9, 5, P_W'(64'hB000 + k));
            exp_q[2].push_back(p);
            send1(0, p);
            if (k < 4) chk($sformatf("bp_ready%0d", k), PKT_W'(bus.in_ready[0]), PKT_W'(1));
        end
        chk("bp_full_ready", PKT_W'(bus.in_ready[0]), PKT_W'(0));
        bus.in_valid[0]  = 1'b1;
        bus.in_packet[0] = mk(1'b1, 9, 5, P_W'(64'hBFFF));
        repeat (3) @(posedge clk);
        #1;
        chk("bp_still_full", PKT_W'(bus.in_ready[0]), PKT_W'(0));
        chk("bp_out_valid", PKT_W'(bus.out_valid[2]), PKT_W'(1));
        chk("bp_out_head", bus.out_packet[2], p0);
        bus.in_valid[0] = 1'b0;
        bus.out_ready = 5'h1f;
        wait_drain();
        chk("bp_ready_recover", PKT_W'(bus.in_ready[0]), PKT_W'(1));

        // Round-robin on Local output: inputs 1..4, 3 packets each
        do_reset();
        bus.out_ready = 5'h1f;
        for (int r = 0; r < 3; r++)
            for (int i = 1; i < 5; i++) exp_q[0].push_back(mk(1'b0, 5, 5, P_W'(i * 16 + r)));
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("rr_ready%0d", r), PKT_W'(bus.in_ready[4:1]), PKT_W'(4'hf));
            for (int i = 1; i < 5; i++) bus.in_packet[i] = mk(1'b0, 5, 5, P_W'(i * 16 + r));
            bus.in_valid = 5'b11110;
            @(posedge clk); #1;
        end
        bus.in_valid = '0;
        wait_drain();

        // Simultaneous Local->East and North->South
        do_reset();
        bus.out_ready = 5'h1f;
        p0 = mk(1'b0, 7, 5, P_W'(64'h1_0000_2222));
        p1 = mk(1'b1, 5, 1, P_W'(64'hDEAD_BEEF));
        exp_q[2].push_back(p0);
        exp_q[3].push_back(p1);
        bus.in_packet[0] = p0;
        bus.in_packet[1] = p1;
        bus.in_valid = 5'b00011;
        @(posedge clk); #1;
        bus.in_valid = '0;
        chk("sim_early", PKT_W'(bus.out_valid[3:2]), PKT_W'(0));
        @(posedge clk); #1;
        chk("sim_both", PKT_W'(bus.out_valid[3:2]), PKT_W'(2'b11));
        wait_drain();
        // Streaming push+pop on one FIFO keeps occupancy at 1, so in_ready never drops
        for (int k = 0; k < 6; k++) begin
            p = mk(1'b1, 8, 2, P_W'(64'hC000 + k));
            exp_q[2].push_back(p);
            send1(0, p);
            chk($sformatf("stream_ready%0d", k), PKT_W'(bus.in_ready[0]), PKT_W'(1));
        end
        wait_drain();

        // Reset mid-traffic with 3 packets buffered
        do_reset();
        bus.out_ready = '0;
        for (int k = 0; k < 3; k++) send1(0, mk(1'b1, 7, 5, P_W'(64'hE000 + k)));
        chk("mid_valid_before", PKT_W'(bus.out_valid[2]), PKT_W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_valid", PKT_W'(bus.out_valid), PKT_W'(0));
        chk("mid_async_pkt", bus.out_packet[2], '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 5'h1f;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_stale", PKT_W'(bus.out_valid), PKT_W'(0));
        chk("mid_in_ready", PKT_W'(bus.in_ready), PKT_W'(5'h1f));

`ifdef MESH_ROUTER_STATS_EN
        do_reset();
        bus.out_ready = 5'h1f;
        for (int k = 0; k < 10; k++) begin
            p = mk(1'b1, 12, 5, P_W'(64'hF000 + k));
            exp_q[2].push_back(p);
            send1(0, p);
        end
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        for (int o = 0; o < 5; o++)
            chk($sformatf("stats%0d", o), PKT_W'(bus.out_count[o]), PKT_W'((o == 2) ? 10 : 0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
